// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a DIGITS-wide common-cathode 7-segment display.
// One digit is lit per slot of CLK_DIV cycles. The first BLANK_CYCLES cycles of
// each slot are fully dark to suppress ghosting. Display data is double
// buffered. A load goes into a pending buffer, and that buffer is promoted to
// the active buffer only at a frame boundary, so a frame never shows mixed data.
//
// Optional feature: define SEG7_HEX_EN to decode nibbles 10..15 as A b C d E F.
// When it is undefined, those nibbles are shown dark.
//
// Parameters:
//   DIGITS        number of scanned digits (>= 1)
//   CLK_DIV       clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  dark cycles at the start of each slot (< CLK_DIV, 0 = none)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        capture data/dp/blank into the pending buffer
//   data        4*DIGITS BCD nibbles, nibble 0 = rightmost digit
//   dp          decimal point request per digit
//   blank       force digit dark per digit
//   segments    {g,f,e,d,c,b,a}, active high, registered
//   dp_out      decimal point of the lit digit, registered
//   digit_en    one-hot (or all-zero) digit select, registered
//   frame_done  one-cycle pulse with the first output cycle of each new frame
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            segments,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] D_LAST  = DW'(DIGITS - 1);

    // Scan position
    logic [PW-1:0]          p_reg;
    logic [DW-1:0]          d_reg;

    // Pending and active display buffers
    logic [4*DIGITS-1:0]    pend_data_reg;
    logic [DIGITS-1:0]      pend_dp_reg;
    logic [DIGITS-1:0]      pend_blank_reg;
    logic                   pend_valid_reg;
    logic [4*DIGITS-1:0]    act_data_reg;
    logic [DIGITS-1:0]      act_dp_reg;
    logic [DIGITS-1:0]      act_blank_reg;

    // Registered outputs
    logic [6:0]             segments_reg;
    logic                   dp_out_reg;
    logic [DIGITS-1:0]      digit_en_reg;
    logic                   frame_done_reg;
    // High while the scan state is the (0,0) that follows a frame wrap, so the
    // post-reset (0,0) does not produce a frame_done pulse.
    logic                   wrap_reg;

    logic                   slot_last;
    logic                   frame_last;
    logic                   in_gap;
    logic [3:0]             act_nibble [DIGITS];
    logic [DIGITS-1:0]      sel_onehot;
    logic [6:0]             segments_next;
    logic                   dp_out_next;
    logic [DIGITS-1:0]      digit_en_next;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
`ifdef SEG7_HEX_EN
            4'd10:   s = 7'b1110111;
            4'd11:   s = 7'b1111100;
            4'd12:   s = 7'b0111001;
            4'd13:   s = 7'b1011110;
            4'd14:   s = 7'b1111001;
            default: s = 7'b1110001;
`else
            default: s = 7'b0000000;
`endif
        endcase
        return s;
    endfunction

    assign slot_last  = (p_reg == P_LAST);
    assign frame_last = slot_last && (d_reg == D_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign act_nibble[gi] = act_data_reg[4*gi +: 4];
            assign sel_onehot[gi] = (d_reg == DW'(gi));
        end

        // With no gap configured the comparison is dropped entirely rather
        // than comparing against zero.
        if (BLANK_CYCLES > 0) begin : g_gap
            assign in_gap = (p_reg < PW'(BLANK_CYCLES));
        end else begin : g_no_gap
            assign in_gap = 1'b0;
        end
    endgenerate

    always_comb begin
        segments_next = 7'd0;
        dp_out_next   = 1'b0;
        digit_en_next = '0;
        if (!in_gap) begin
            digit_en_next = sel_onehot;
            if (!act_blank_reg[d_reg]) begin
                segments_next = seg7_decode(act_nibble[d_reg]);
                dp_out_next   = act_dp_reg[d_reg];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg          <= '0;
            d_reg          <= '0;
            pend_data_reg  <= '0;
            pend_dp_reg    <= '0;
            pend_blank_reg <= '0;
            pend_valid_reg <= 1'b0;
            act_data_reg   <= '0;
            act_dp_reg     <= '0;
            act_blank_reg  <= '1;
            segments_reg   <= 7'd0;
            dp_out_reg     <= 1'b0;
            digit_en_reg   <= '0;
            frame_done_reg <= 1'b0;
            wrap_reg       <= 1'b0;
        end else begin
            // Scan counters
            if (slot_last) begin
                p_reg <= '0;
                d_reg <= (d_reg == D_LAST) ? '0 : d_reg + 1'b1;
            end else begin
                p_reg <= p_reg + 1'b1;
            end

            // Promotion uses the flag as it stood before this edge, so a load
            // landing on the boundary cycle waits for the next boundary.
            if (frame_last && pend_valid_reg) begin
                act_data_reg  <= pend_data_reg;
                act_dp_reg    <= pend_dp_reg;
                act_blank_reg <= pend_blank_reg;
            end

            if (load) begin
                pend_data_reg  <= data;
                pend_dp_reg    <= dp;
                pend_blank_reg <= blank;
                pend_valid_reg <= 1'b1;
            end else if (frame_last) begin
                pend_valid_reg <= 1'b0;
            end

            segments_reg   <= segments_next;
            dp_out_reg     <= dp_out_next;
            digit_en_reg   <= digit_en_next;
            wrap_reg       <= frame_last;
            frame_done_reg <= wrap_reg;
        end
    end

    assign segments   = segments_reg;
    assign dp_out     = dp_out_reg;
    assign digit_en   = digit_en_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
// The bench tracks kcnt, the index of the scan state shown on the outputs
// (kcnt=0 is the first output cycle after reset release). Expected outputs are
// derived from kcnt and hand-computed segment patterns.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 8;
    localparam int BLANK   = 2;
    localparam int FRAME   = DIGITS * CLK_DIV;

`ifdef SEG7_HEX_EN
    localparam logic [6:0] SEG_A = 7'b1110111;
`else
    localparam logic [6:0] SEG_A = 7'b0000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [6:0]  segments;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int kcnt     = -1;

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data       (data),
        .dp         (dp),
        .blank      (blank),
        .segments   (segments),
        .dp_out     (dp_out),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move from one negedge to the next, crossing exactly one rising edge.
    task automatic advance();
        @(posedge clk);
        @(negedge clk);
        kcnt++;
    endtask

    task automatic advance_to(input int target);
        while (kcnt < target) advance();
    endtask

    // One-cycle load pulse; captured on the rising edge inside advance().
    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data  = d;
        dp    = p;
        blank = b;
        load  = 1'b1;
        $display("load data=%h dp=%b blank=%b at k=%0d", d, p, b, kcnt);
        advance();
        load  = 1'b0;
    endtask

    // Checks a whole frame starting at a frame-aligned kcnt. segs packs the
    // expected pattern for digits {3,2,1,0}; blanked digits are given as 0.
    task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] dps);
        int         d;
        int         p;
        logic [3:0] en_exp;
        logic [6:0] seg_exp;
        logic       dp_exp;
        logic       fd_exp;
        int         fail_before;
        fail_before = n_fail;
        for (int i = 0; i < FRAME; i++) begin
            d = (kcnt / CLK_DIV) % DIGITS;
            p = kcnt % CLK_DIV;
            if (p < BLANK) begin
                en_exp  = 4'b0000;
                seg_exp = 7'd0;
                dp_exp  = 1'b0;
            end else begin
                en_exp  = 4'b0001 << d;
                seg_exp = segs[7*d +: 7];
                dp_exp  = dps[d];
            end
            fd_exp = (kcnt % FRAME == 0) && (kcnt != 0);
            check($sformatf("%s digit_en k=%0d", name, kcnt), 32'(digit_en), 32'(en_exp));
            check($sformatf("%s segments k=%0d", name, kcnt), 32'(segments), 32'(seg_exp));
            check($sformatf("%s dp_out k=%0d", name, kcnt), 32'(dp_out), 32'(dp_exp));
            check($sformatf("%s frame_done k=%0d", name, kcnt), 32'(frame_done), 32'(fd_exp));
            advance();
        end
        $display("frame %s ending k=%0d: %0d new failures", name, kcnt, n_fail - fail_before);
    endtask

    initial begin
        // Reset held
        repeat (3) @(negedge clk);
        check("rst segments", 32'(segments), 32'd0);
        check("rst dp_out", 32'(dp_out), 32'd0);
        check("rst digit_en", 32'(digit_en), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);

        rst_n = 1'b1;
        kcnt  = -1;
        advance();

        // Idle after reset: everything blanked, scan still running
        check_frame("idle0", 28'd0, 4'b0000);

        // Load 1234 mid-frame 1, shows from frame 2
        do_load(16'h1234, 4'b0100, 4'b0000);
        advance_to(2 * FRAME);
        check_frame("f1234", {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}, 4'b0100);

        // Two loads within frame 3: last one wins
        do_load(16'h1111, 4'b0000, 4'b0000);
        advance_to(3 * FRAME + 4);
        do_load(16'h9876, 4'b0000, 4'b0000);
        advance_to(4 * FRAME);
        check_frame("f9876", {7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101}, 4'b0000);

        // Load exactly on the boundary cycle (state index 6*FRAME-1)
        advance_to(6 * FRAME - 2);
        do_load(16'h0000, 4'b1001, 4'b0000);
        advance_to(6 * FRAME);
        check_frame("boundary_old", {7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101}, 4'b0000);
        check_frame("boundary_new", {4{7'b0111111}}, 4'b1001);

        // Hex nibble on digit 0; others blanked (blank masks dp on digit 1)
        do_load(16'h000A, 4'b0010, 4'b1110);
        advance_to(9 * FRAME);
        check_frame("hexA", {7'd0, 7'd0, 7'd0, SEG_A}, 4'b0000);

        // Pending load just before an asynchronous reset in digit 2's slot
        advance_to(10 * FRAME + 18);
        do_load(16'h4444, 4'b1111, 4'b0000);
        advance_to(10 * FRAME + 20);
        check("pre-reset digit_en", 32'(digit_en), 32'b0100);
        check("pre-reset segments", 32'(segments), 32'(7'd0));
        rst_n = 1'b0;
        #1;
        check("async segments", 32'(segments), 32'd0);
        check("async dp_out", 32'(dp_out), 32'd0);
        check("async digit_en", 32'(digit_en), 32'd0);
        check("async frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        kcnt  = -1;
        advance();
        check_frame("post_rst0", 28'd0, 4'b0000);
        check_frame("post_rst1", 28'd0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a DIGITS-wide common-cathode 7-segment display. It scans one digit at a time at a programmable rate and decodes each BCD nibble with the team's standard segment map. A double-buffered load prevents mid-frame tearing, and per-digit blanking, decimal points and a configurable ghost-suppression gap are included. It sits between the numeric datapath (counters, measurement logic) and the board's segment/digit pins.

## Interface
- DIGITS, 4: number of digits scanned; must be ≥1.
- CLK_DIV, 1000: clock cycles per digit slot; must be ≥2.
- BLANK_CYCLES, 1: cycles at the start of each slot with all outputs dark; must be < CLK_DIV; 0 disables the gap.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  capture data/dp/blank into the pending buffer this cycle.
- data  in  4*DIGITS  nibble i (bits 4i+3:4i) is the value for digit i; digit 0 is rightmost.
- dp  in  DIGITS  decimal point request per digit.
- blank  in  DIGITS  force digit dark when 1.
- segments  out  7  bit0=a … bit6=g, active high, registered.
- dp_out  out  1  decimal point of the current digit, active high, registered.
- digit_en  out  DIGITS  one-hot (or all-zero) digit select, active high, registered.
- frame_done  out  1  one-cycle pulse at each frame boundary, registered.

## Operation
- Internal state: prescaler p in 0..CLK_DIV-1 and digit index d in 0..DIGITS-1; reset value (0,0).
- Each cycle p increments. At p=CLK_DIV-1, p wraps to 0 and d advances; d wraps from DIGITS-1 to 0.
- Frame boundary is the transition (d=DIGITS-1, p=CLK_DIV-1) → (0,0).
- Pending buffer: on load=1, data/dp/blank are copied into pending and a pending flag is set. A second load before the boundary overwrites pending; the last one wins.
- Active buffer: at a frame boundary with the flag set, pending is copied to active and the flag is cleared. Reset clears active data/dp to 0, sets active blank to all ones, and clears the flag.
- load in the same cycle as a boundary goes to pending and is applied at the following boundary, never at the current one.
- Decode for the nibble:
  - 0 → 0111111
  - 1 → 0000110
  - 2 → 1011011
  - 3 → 1001111
  - 4 → 1100110
  - 5 → 1101101
  - 6 → 1111101
  - 7 → 0000111
  - 8 → 1111111
  - 9 → 1101111
  - 10–15 → see Configuration.
- Output for state (d,p):
  - If p < BLANK_CYCLES: segments=0, dp_out=0, digit_en=0.
  - Else if active blank[d]=1: digit_en has bit d set, segments=0, dp_out=0.
  - Else: digit_en has bit d set, segments=decode(active nibble d), dp_out=active dp[d].

## Timing
- Outputs are registered: in the cycle after the internal state is (d,p), the outputs reflect (d,p) using the active buffer as it stood in that state.
- Reset values: segments=0, dp_out=0, digit_en=0, frame_done=0.
- After rst_n is released, the first edge registers outputs for state (0,0).
- frame_done is high for exactly one cycle, coinciding with the output cycle for state (0,0) of each new frame. It is not asserted for the post-reset (0,0).
- Load-to-display latency: the value first appears in the output cycle of (0,0) after the next boundary. Worst case is DIGITS*CLK_DIV+1 cycles.
- Each slot lasts CLK_DIV cycles, of which CLK_DIV-BLANK_CYCLES have digit_en asserted. A frame lasts DIGITS*CLK_DIV cycles.
- Asserting rst_n low mid-frame immediately clears outputs, state, the pending flag and the active buffer; no partial frame resumes.

## Configuration
- SEG7_HEX_EN defined: nibbles 10–15 decode to:
  - A → 1110111
  - b → 1111100
  - C → 0111001
  - d → 1011110
  - E → 1111001
  - F → 1110001
- SEG7_HEX_EN undefined: nibbles 10–15 decode to 0000000 (digit dark, digit_en still asserted). dp_out is unaffected.

## Test plan
All scenarios use DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
- Reset then idle: all outputs 0 during reset. After release, digit_en cycles 0001→0010→0100→1000 with 6 active cycles per 8, and segments=0 throughout (all blanked).
- Load data=16'h1234, dp=4'b0100, blank=0: from the next frame, digit0 shows 1100110, digit1 1001111, digit2 1011011 with dp_out=1, digit3 0000110. frame_done pulses every 32 cycles.
- Two loads in one frame (16'h1111 then 16'h9876): only 9876 is ever displayed; 1111 never appears.
- Load asserted in the exact boundary cycle: the old value is shown for the whole next frame and the new value in the frame after.
- Nibble 4'hA on digit 0: segments=1110111 with SEG7_HEX_EN, 0000000 without, digit_en bit0 asserted in both builds.
- rst_n pulled low mid-slot of digit 2: outputs read 0 asynchronously. After release, scanning restarts at digit 0 with all digits blanked until a new load.
